// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: MSB-first bit stream with frame qualifier, falling-edge clocked.
// Optional even-parity bit after d[0] when PISO_PARITY_EN is defined.
module piso_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             frame,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = WIDTH - 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]    state, state_n;
  logic [SW-1:0] sreg, sreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          so_n, frame_n;
  logic          accept;
  logic          last_cycle;
`ifdef PISO_PARITY_EN
  logic          par, par_n;
`endif

  // Final framed cycle: the slot in which the next word may be accepted without a gap.
`ifdef PISO_PARITY_EN
  assign last_cycle = (state == PARITY);
`else
  assign last_cycle = (state == SHIFT) && (cnt == '0);
`endif

  assign load_ready = !rst && ((state == IDLE) || last_cycle);
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      so    <= 1'b0;
      frame <= 1'b0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      so    <= so_n;
      frame <= frame_n;
`ifdef PISO_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    so_n    = so;
    frame_n = frame;
`ifdef PISO_PARITY_EN
    par_n   = par;
`endif
    if (accept) begin
      // MSB goes out immediately; the remainder waits left-aligned in sreg.
      state_n = SHIFT;
      so_n    = d[WIDTH-1];
      frame_n = 1'b1;
      sreg_n  = d[WIDTH-2:0];
      cnt_n   = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
      par_n   = ^d;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            so_n   = sreg[SW-1];
            sreg_n = sreg << 1;
            cnt_n  = cnt - CW'(1);
          end else begin
`ifdef PISO_PARITY_EN
            state_n = PARITY;
            so_n    = par;
`else
            state_n = IDLE;
            so_n    = 1'b0;
            frame_n = 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_n = IDLE;
          so_n    = 1'b0;
          frame_n = 1'b0;
        end
`endif
        IDLE: begin
          so_n    = 1'b0;
          frame_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          so_n    = 1'b0;
          frame_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: expected bits queued at each accepted load, popped per framed cycle.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d = 4'b0;
  logic       load_valid = 1'b0;
  logic       load_ready, so, frame, busy;

  logic       q[$];
  int         checks = 0;
  int         failures = 0;
  int         frame_cycles = 0;
  logic       exp_bit;
  logic [3:0] sipo;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  piso_tx #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid),
    .load_ready(load_ready), .so(so), .frame(frame), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference 4-bit receiver: shifts so in on the same falling edge while framed.
  always @(negedge clk or posedge rst) begin
    if (rst) sipo <= 4'b0;
    else if (frame) sipo <= {sipo[2:0], so};
  end

  // Monitor at rising edge, mid-way between the DUT's update edges.
  always @(posedge clk) begin
    if (!rst) begin
      check("frame_vs_sb", 32'(frame), 32'(q.size() != 0));
      if (frame) begin
        frame_cycles++;
        check("ready_last", 32'(load_ready), 32'(q.size() == 1));
        if (q.size() != 0) begin
          exp_bit = q.pop_front();
          check("so_bit", 32'(so), 32'(exp_bit));
        end
      end else begin
        check("so_idle", 32'(so), 32'd0);
      end
    end
  end

  task automatic push_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    q.push_back(^w);
`endif
  endtask

  // Called just after a rising edge; returns just after the rising edge following the accept.
  task automatic load_word(input logic [3:0] w);
    int n = 0;
    d = w;
    load_valid = 1'b1;
    while (!load_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!load_ready) check("ready_timeout", 32'd0, 32'd1);
    else push_word(w);
    @(negedge clk);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    check("idle_so", 32'(so), 32'd0);
    check("idle_frame", 32'(frame), 32'd0);
    check("idle_ready", 32'(load_ready), 32'd1);
    check("sb_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_so", 32'(so), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_ready", 32'(load_ready), 32'd1);
    @(posedge clk); #1;

    // Single word
    frame_cycles = 0;
    load_word(4'b1011);
    wait_idle();
    check("single_len", 32'(frame_cycles), 32'(FLEN));
`ifndef PISO_PARITY_EN
    check("single_sipo", 32'(sipo), 32'b1011);
`endif

    // Back-to-back, gapless
    frame_cycles = 0;
    load_word(4'b1011);
    load_word(4'b0110);
    wait_idle();
    check("b2b_len", 32'(frame_cycles), 32'(2 * FLEN));
`ifndef PISO_PARITY_EN
    check("b2b_sipo", 32'(sipo), 32'b0110);
`endif

    // Load attempt while busy is ignored
    frame_cycles = 0;
    load_word(4'b0000);
    @(posedge clk); #1;
    d = 4'b1111;
    load_valid = 1'b1;
    check("busy_not_ready", 32'(load_ready), 32'd0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_idle();
    check("ignored_len", 32'(frame_cycles), 32'(FLEN));
`ifndef PISO_PARITY_EN
    check("ignored_sipo", 32'(sipo), 32'b0000);
`endif

    // Asynchronous reset mid-frame
    load_word(4'b1011);
    @(posedge clk); #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("mid_rst_so", 32'(so), 32'd0);
    check("mid_rst_frame", 32'(frame), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("mid_rel_ready", 32'(load_ready), 32'd1);
    @(posedge clk); #1;
    frame_cycles = 0;
    load_word(4'b0101);
    wait_idle();
    check("after_rst_len", 32'(frame_cycles), 32'(FLEN));
`ifndef PISO_PARITY_EN
    check("after_rst_sipo", 32'(sipo), 32'b0101);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
